dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through data cache controller between the processor's data-cache bus and the data RAM. It answers processor loads that hit in one cycle with no stall. Misses and all stores go to RAM over the en/rw/addr/data/miss memory protocol. While a memory transaction is outstanding, the controller drives the processor's miss line high to stall it. Lines are one word each, so every store writes a full line.

## Interface
- ADDR_WIDTH, 32, word-address width on both sides
- DATA_WIDTH, 32, data word width
- INDEX_BITS, 6, log2 of line count (64 lines); tag = addr[ADDR_WIDTH-1:INDEX_BITS], index = addr[INDEX_BITS-1:0]
- Clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- cpu_en  in  1  processor access request
- cpu_rw  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdata  out  DATA_WIDTH  load data; 0 except on read hit or fill completion
- cpu_miss  out  1  stall; processor holds en/rw/addr/wdata stable while high
- mem_en  out  1  memory request
- mem_rw  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid in completion cycle
- mem_miss  in  1  memory not ready; sampled only while mem_en=1
- hit_cnt  out  16  read-hit counter, saturates at 0xFFFF
- miss_cnt  out  16  read-miss counter, saturates at 0xFFFF

## Operation
- Storage:
  - valid[2^INDEX_BITS], cleared by Rst.
  - Tag and data arrays are not reset.
- Lookup: combinational. hit = valid[index] && tag_arr[index]==tag.
- FSM states: IDLE, FILL, WRITE.
- IDLE, cpu_en=0: cpu_miss=0, no state change.
- IDLE, read hit:
  - cpu_rdata=data_arr[index], cpu_miss=0 same cycle.
  - hit_cnt++.
- IDLE, read miss:
  - cpu_miss=1.
  - Latch addr into mem_addr; mem_rw=0.
  - Go FILL; miss_cnt++.
- IDLE, write (hit or miss):
  - cpu_miss=1.
  - Latch addr/wdata; mem_rw=1.
  - Go WRITE.
  - Write is not counted in hit_cnt or miss_cnt.
- FILL:
  - mem_en=1, cpu_miss=1 while mem_miss=1.
  - Completion cycle (mem_miss=0): cpu_rdata=mem_rdata, cpu_miss=0.
  - Same edge: write data_arr/tag_arr[index], set valid; go IDLE.
- WRITE:
  - mem_en=1 until mem_miss=0.
  - Completion cycle: cpu_miss=0.
  - Same edge: data_arr/tag_arr/valid updated (write-allocate, full-line); go IDLE.
- mem_en=1 exactly when state != IDLE.
- mem_addr, mem_rw and mem_wdata are held constant for the whole transaction.
- Counters saturate and never wrap.

## Timing
- Reset values: state=IDLE, valid all 0, mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, hit_cnt=0, miss_cnt=0.
- With cpu_en=0 out of reset: cpu_miss=0, cpu_rdata=0.
- Read hit latency: 0 stall cycles.
- Read miss or write latency: 1 + N stall cycles, where N = cycles mem_miss stays high after mem_en rises. The minimum is 1 stall cycle.
- After completion, the processor presents its next request the following cycle.
  - A read to the just-filled or just-written address then hits.
- Rst asserted mid-FILL or mid-WRITE:
  - Next edge: state=IDLE, mem_en=0, valid cleared.
  - The transaction is abandoned; no array update.
- Rst has priority over any completion in the same cycle.
- Index aliasing: a fill or write to an index replaces the old tag. The next access to the old tag misses.
- mem_miss while mem_en=0 is ignored.

## Test plan
- Reset, then read addr 0x10 with RAM[0x10]=0xDEADBEEF and mem_miss=0 -> 1 stall cycle, cpu_rdata=0xDEADBEEF at completion; miss_cnt=1. Repeat read -> cpu_miss=0, same data, hit_cnt=1.
- Write 0x12345678 to 0x20 with mem_miss held high 3 cycles -> mem_en high 4 cycles, mem_rw=1, mem_addr=0x20; cpu_miss=1 for 4 cycles. Then read 0x20 -> hit, 0x12345678, no mem_en.
- Aliasing: read 0x05, then read 0x45 (same index, INDEX_BITS=6), then read 0x05 -> three misses, miss_cnt=3, correct data each time.
- Assert Rst on the second cycle of a FILL with mem_miss=1 -> next cycle mem_en=0, state IDLE. Read of the same address afterward misses.
- Saturation: force 65537 read hits -> hit_cnt=0xFFFF, no wrap.
- Idle: cpu_en=0 for 10 cycles -> mem_en=0, cpu_miss=0, counters unchanged.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through D-cache: read hits answer in the same cycle with no stall;
// read misses and all stores go to RAM and stall the CPU for 1 + N cycles, where N = mem_miss cycles.
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  cpu_en,
  input  logic                  cpu_rw,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_miss,
  output logic                  mem_en,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_miss,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t                r_state, w_next_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag_arr  [LINES];
  logic [DATA_WIDTH-1:0] r_data_arr [LINES];
  logic                  r_mem_rw;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [15:0]           r_hit_cnt, r_miss_cnt;

  logic [INDEX_BITS-1:0] w_index, w_m_index;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit, w_rd_hit, w_rd_miss, w_wr_req, w_done;
  logic [DATA_WIDTH-1:0] w_line_data;

  assign w_index     = cpu_addr[INDEX_BITS-1:0];
  assign w_tag       = cpu_addr[ADDR_WIDTH-1:INDEX_BITS];
  assign w_m_index   = r_mem_addr[INDEX_BITS-1:0];
  assign w_hit       = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);
  assign w_rd_hit    = (r_state == S_IDLE) && cpu_en && !cpu_rw && w_hit;
  assign w_rd_miss   = (r_state == S_IDLE) && cpu_en && !cpu_rw && !w_hit;
  assign w_wr_req    = (r_state == S_IDLE) && cpu_en && cpu_rw;
  assign w_done      = (r_state != S_IDLE) && !mem_miss;
  assign w_line_data = (r_state == S_WRITE) ? r_mem_wdata : mem_rdata;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= 16'd0;
      r_miss_cnt  <= 16'd0;
    end else begin
      r_state <= w_next_state;
      if (w_rd_miss || w_wr_req) begin
        r_mem_addr <= cpu_addr;
        r_mem_rw   <= cpu_rw;
        if (cpu_rw) r_mem_wdata <= cpu_wdata;
      end
      if (w_done) r_valid[w_m_index] <= 1'b1;
      if (w_rd_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_rd_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  // Tag/data arrays carry no reset; reset only blocks an in-flight completion.
  always_ff @(posedge Clk) begin
    if (!Rst && w_done) begin
      r_tag_arr[w_m_index]  <= r_mem_addr[ADDR_WIDTH-1:INDEX_BITS];
      r_data_arr[w_m_index] <= w_line_data;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wr_req)       w_next_state = S_WRITE;
        else if (w_rd_miss) w_next_state = S_FILL;
      end
      S_FILL, S_WRITE: if (!mem_miss) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_miss  = 1'b0;
    cpu_rdata = '0;
    mem_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_miss = cpu_en && !w_rd_hit;
        if (w_rd_hit) cpu_rdata = r_data_arr[w_index];
      end
      S_FILL: begin
        mem_en   = 1'b1;
        cpu_miss = mem_miss;
        if (!mem_miss) cpu_rdata = mem_rdata;
      end
      S_WRITE: begin
        mem_en   = 1'b1;
        cpu_miss = mem_miss;
      end
      default: ;
    endcase
  end

  assign mem_rw    = r_mem_rw;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Random and directed bench: acts as CPU and RAM, predicts every output from a line-level cache model.
module tb_dcache_ctrl;
  logic        Clk = 1'b0;
  logic        Rst, cpu_en, cpu_rw, cpu_miss, mem_en, mem_rw, mem_miss;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  int n_vec = 0;
  int n_bad = 0;

  bit          m_valid [64];
  logic [25:0] m_tag   [64];
  logic [31:0] m_data  [64];
  int          m_hits, m_misses;
  logic [31:0] ram [logic [31:0]];

  dcache_ctrl dut (
    .Clk(Clk), .Rst(Rst), .cpu_en(cpu_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_miss(cpu_miss),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_miss(mem_miss), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : ((a * 32'h9E3779B9) ^ 32'h5A5A_A5A5);
  endfunction

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_cnt();
    check("hit_cnt", {16'h0, hit_cnt}, m_hits);
    check("miss_cnt", {16'h0, miss_cnt}, m_misses);
  endtask

  // One processor access; n = cycles mem_miss stays high once mem_en rises.
  task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] wd, input int n);
    logic [5:0]  idx;
    logic [25:0] tg;
    bit          hit;
    logic [31:0] rv;
    idx = a[5:0];
    tg  = a[31:6];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    rv  = ram_rd(a);
    #1;
    cpu_en = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
    mem_miss  = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge Clk);
    check_cnt();
    check("cpu_miss_req", cpu_miss, rw || !hit);
    check("mem_en_req", mem_en, 1'b0);
    check("cpu_rdata_req", cpu_rdata, (!rw && hit) ? m_data[idx] : 32'h0);
    @(posedge Clk);
    if (!rw && hit) begin
      m_hits = sat16(m_hits + 1);
      return;
    end
    if (!rw) m_misses = sat16(m_misses + 1);
    for (int k = 1; k <= n + 1; k++) begin
      #1;
      mem_miss  = (k <= n);
      mem_rdata = (k <= n) ? $urandom : rv;
      @(negedge Clk);
      check("mem_en_busy", mem_en, 1'b1);
      check("mem_rw", mem_rw, rw);
      check("mem_addr", mem_addr, a);
      if (rw) check("mem_wdata", mem_wdata, wd);
      check("cpu_miss_busy", cpu_miss, k <= n);
      check("cpu_rdata_busy", cpu_rdata, (k <= n || rw) ? 32'h0 : rv);
      @(posedge Clk);
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    m_data[idx]  = rw ? wd : rv;
    if (rw) ram[a] = wd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      cpu_en = 1'b0; cpu_rw = 1'($urandom); cpu_addr = $urandom;
      mem_miss = 1'($urandom);
      @(negedge Clk);
      check("idle_mem_en", mem_en, 1'b0);
      check("idle_cpu_miss", cpu_miss, 1'b0);
      check("idle_cpu_rdata", cpu_rdata, 32'h0);
      check_cnt();
      @(posedge Clk);
    end
  endtask

  initial begin
    logic [31:0] a;
    Rst = 1'b1; cpu_en = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_miss = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_rw", mem_rw, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_miss", cpu_miss, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check_cnt();
    Rst = 1'b0;
    @(posedge Clk);

    ram[32'h10] = 32'hDEADBEEF;
    access(1'b0, 32'h10, 32'h0, 0);
    access(1'b0, 32'h10, 32'h0, 0);
    access(1'b1, 32'h20, 32'h12345678, 3);
    access(1'b0, 32'h20, 32'h0, 0);
    access(1'b0, 32'h05, 32'h0, 1);
    access(1'b0, 32'h45, 32'h0, 2);
    access(1'b0, 32'h05, 32'h0, 0);
    idle(1);

    // Reset lands on the second FILL cycle together with a would-be completion.
    #1;
    cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h33; mem_miss = 1'b1;
    @(negedge Clk);
    check("rstfill_req_miss", cpu_miss, 1'b1);
    @(posedge Clk);
    #1 mem_miss = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b1; mem_miss = 1'b0; mem_rdata = 32'hBAD0BAD0;
    @(negedge Clk);
    check("rstfill_mem_en", mem_en, 1'b1);
    @(posedge Clk);
    #1;
    Rst = 1'b0; cpu_en = 1'b0;
    model_reset();
    @(negedge Clk);
    check("rstfill_after_mem_en", mem_en, 1'b0);
    check("rstfill_after_cpu_miss", cpu_miss, 1'b0);
    check_cnt();
    @(posedge Clk);
    access(1'b0, 32'h33, 32'h0, 1);
    access(1'b0, 32'h10, 32'h0, 0);
    idle(10);

    for (int i = 0; i < 400; i++) begin
      a = (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      access(1'($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 3));
    end

    access(1'b0, 32'h10, 32'h0, 0);
    for (int i = 0; i < 65537; i++) access(1'b0, 32'h10, 32'h0, 0);
    idle(2);
    check("hit_cnt_saturated", {16'h0, hit_cnt}, 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
